wb_multi_stage: RTL and testbench
=================================

// Module: wb_multi_stage
// PURPOSE
//  Multi-channel write-back stage. Merges NUM_CH result streams (ch0 = EXE_MEM pipe, ch1+ = long-latency
//  units such as load/mul-div) into the single Regfile write port. Buffers each channel in a FIFO,
//  arbitrates per ARB_MODE, drops x0 writes, and reports pending writes per address for decode stalls.
//  Sits between EXE_MEM/long-latency units and Regfile.
// PARAMETERS
//  DATA_W      32  register data width
//  ADDR_W      5   register address width
//  NUM_CH      2   write channels, >=1
//  FIFO_DEPTH  4   entries per channel FIFO, power of 2, >=2
//  ARB_MODE    0   0 = fixed priority (lowest index wins), 1 = round-robin
// PORTS
//  clk_i_WB        in   1               clock, rising edge
//  rst_n_i_WB      in   1               asynchronous reset, active-low
//  flush_i_WB      in   1               synchronous flush of all buffered writes
//  Wt_Valid_i_WB   in   NUM_CH          per-channel write request
//  Wt_Ready_o_WB   out  NUM_CH          per-channel accept (FIFO not full)
//  Wt_Data_i_WB    in   NUM_CH*DATA_W   packed data, ch k at [k*DATA_W +: DATA_W]
//  Wt_Addr_i_WB    in   NUM_CH*ADDR_W   packed addr, ch k at [k*ADDR_W +: ADDR_W]
//  Query_Addr_i_WB in   ADDR_W          register address checked for pending write
//  Query_Busy_o_WB out  1               pending write to Query_Addr exists (comb)
//  Wt_Data_o_WB    out  DATA_W          to Regfile, registered
//  Wt_Addr_o_WB    out  ADDR_W          to Regfile, registered
//  Wt_Enable_o_WB  out  1               to Regfile write enable, registered
//  Idle_o_WB       out  1               all FIFOs empty and Wt_Enable_o_WB low (comb)
// BEHAVIOUR
//  - Reset (rst_n_i_WB low, async): all FIFO pointers/counts 0, RR pointer 0, Wt_Data/Addr 0,
//    Wt_Enable 0. Wt_Ready = all 1 after deassertion; Query_Busy 0; Idle 1.
//  - Accept: ch k accepted on edge where Valid[k] & Ready[k]. Ready[k] = !full[k], independent of
//    same-cycle pop (full FIFO never accepts, even if popped that cycle).
//  - Addr==0: accepted (handshake completes) but never enqueued; never reaches Regfile.
//  - Per channel strict FIFO order; no ordering across channels (decode must stall via Query_Busy).
//  - Arbitration each cycle over non-empty FIFO heads; one grant per cycle, granted head popped at edge.
//    ARB_MODE 0: lowest index non-empty wins. ARB_MODE 1: search starts at RR pointer; after a grant
//    to k, pointer = (k+1) mod NUM_CH; pointer unchanged when nothing granted.
//  - Output register: on each edge, if grant then Data/Addr <= head, Enable <= 1; else Enable <= 0,
//    Data/Addr hold. Latency: accepted on edge E -> Enable high in cycle after edge E+1 (RF write at
//    E+2) when uncontended. Throughput 1 write/cycle total.
//  - Simultaneous push+pop on one non-full FIFO: both happen, count unchanged.
//  - Pointers wrap mod FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1 distinguishes full/empty.
//  - Query_Busy = any valid FIFO entry with matching addr OR (Wt_Enable_o & Wt_Addr_o match);
//    Query_Addr 0 -> always 0.
//  - Flush: at edge with flush_i_WB=1, all FIFOs emptied, Enable <= 0, RR pointer kept; inputs
//    presented that cycle are dropped even if Ready was high. Flush has priority over push/pop.
//  - Reset mid-operation: buffered writes discarded, no partial Regfile write.
// STRUCTURE
//  - wb_pkg: ARB_FIXED=0/ARB_RR=1, default DATA_W/ADDR_W, ZeroRegData/ZeroRegAddr constants.
//  - Sub-module wb_chan_fifo (DATA_W+ADDR_W wide, FIFO_DEPTH, full/empty, per-entry addr match out),
//    instantiated NUM_CH times via generate; arbiter + output register in top.
// TESTING
//  1 Reset: assert rst_n low mid-traffic -> outputs 0, Ready all 1, Idle 1 immediately (async).
//  2 Single write ch0 addr 5 data 0xDEADBEEF -> Enable high 2nd cycle after accept, Addr 5, one pulse.
//  3 ARB_MODE 0, ch0 and ch1 each push 3 writes same cycles -> all ch0 writes out before any ch1.
//  4 ARB_MODE 1, both channels backlogged -> grants alternate 0,1,0,1; per-channel order preserved.
//  5 Fill ch1 to 4 with no drain (ch0 hogging, mode 0) -> Ready[1]=0; push held until pop frees slot.
//  6 Addr 0 write accepted, never on Enable; pending addr 7 -> Query_Busy 1; flush -> Busy 0, Idle 1.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared constants for the multi-channel write-back stage.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package wb_pkg;

   localparam int ARB_FIXED  = 0;
   localparam int ARB_RR     = 1;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 5;

   // x0 is hard-wired zero in the regfile, so writes to it are discarded
   localparam logic [DEF_DATA_W-1:0] ZeroRegData = '0;
   localparam logic [DEF_ADDR_W-1:0] ZeroRegAddr = '0;

   // Modular increment, used for the round-robin pointer
   function automatic int wrap_inc(input int v, input int n);
      return (v + 1) % n;
   endfunction

endpackage

// File: rtl/wb_chan_fifo.sv
// Per-channel write-back FIFO holding {addr,data}, with a pending-address match output.
// Latency: pushed entry is visible at the head the cycle after the push edge.
// Backpressure: o_full blocks pushes; a same-cycle pop does not free a slot early.
module wb_chan_fifo
   import wb_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DEPTH  = 4
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_flush,
   input  logic              i_push,
   input  logic [ADDR_W-1:0] i_push_addr,
   input  logic [DATA_W-1:0] i_push_dat,
   input  logic              i_pop,
   output logic [ADDR_W-1:0] o_head_addr,
   output logic [DATA_W-1:0] o_head_dat,
   output logic              o_full,
   output logic              o_empty,
   input  logic [ADDR_W-1:0] i_query_addr,
   output logic              o_match
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [ADDR_W-1:0] r_addr_mem [DEPTH];
   logic [DATA_W-1:0] r_dat_mem  [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_cnt;
   logic              w_push;
   logic              w_pop;

   assign o_full      = (r_cnt == CNT_W'(DEPTH));
   assign o_empty     = (r_cnt == '0);
   // Flush wins over both push and pop
   assign w_push      = i_push & ~o_full & ~i_flush;
   assign w_pop       = i_pop & ~o_empty & ~i_flush;
   assign o_head_addr = r_addr_mem[r_rd_ptr];
   assign o_head_dat  = r_dat_mem[r_rd_ptr];

   // Pointer and occupancy tracking; flush empties the queue
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + CNT_W'(1);
            2'b01:   r_cnt <= r_cnt - CNT_W'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   // Entry storage; contents only meaningful inside the occupied window
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_addr_mem[r_wr_ptr] <= i_push_addr;
         r_dat_mem[r_wr_ptr]  <= i_push_dat;
      end
   end

   // Any occupied slot whose address equals the query address
   always_comb begin
      o_match = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if ((CNT_W'(PTR_W'(PTR_W'(i) - r_rd_ptr)) < r_cnt) &&
             (r_addr_mem[i] == i_query_addr)) begin
            o_match = 1'b1;
         end
      end
   end

endmodule

// File: rtl/wb_multi_stage.sv
// Merges NUM_CH write-result streams into the single regfile write port, with pending-write query.
// Latency: accept on edge E -> registered write enable after edge E+1 when uncontended.
// Backpressure: per-channel ready = FIFO not full; one regfile write granted per cycle.
module wb_multi_stage
   import wb_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int NUM_CH     = 2,
   parameter int FIFO_DEPTH = 4,
   parameter int ARB_MODE   = ARB_FIXED
) (
   input  logic                     clk_i_WB,
   input  logic                     rst_n_i_WB,
   input  logic                     flush_i_WB,
   input  logic [NUM_CH-1:0]        Wt_Valid_i_WB,
   output logic [NUM_CH-1:0]        Wt_Ready_o_WB,
   input  logic [NUM_CH*DATA_W-1:0] Wt_Data_i_WB,
   input  logic [NUM_CH*ADDR_W-1:0] Wt_Addr_i_WB,
   input  logic [ADDR_W-1:0]        Query_Addr_i_WB,
   output logic                     Query_Busy_o_WB,
   output logic [DATA_W-1:0]        Wt_Data_o_WB,
   output logic [ADDR_W-1:0]        Wt_Addr_o_WB,
   output logic                     Wt_Enable_o_WB,
   output logic                     Idle_o_WB
);

   localparam int RR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic [NUM_CH-1:0] w_full;
   logic [NUM_CH-1:0] w_empty;
   logic [NUM_CH-1:0] w_match;
   logic [NUM_CH-1:0] w_push_vld;
   logic [NUM_CH-1:0] w_pop;
   logic [ADDR_W-1:0] w_head_addr [NUM_CH];
   logic [DATA_W-1:0] w_head_dat  [NUM_CH];
   logic              w_gnt_vld;
   logic [RR_W-1:0]   w_gnt_idx;
   logic [RR_W-1:0]   r_rr_ptr;
   logic [DATA_W-1:0] r_wt_dat;
   logic [ADDR_W-1:0] r_wt_addr;
   logic              r_wt_en;

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      // x0 writes complete the handshake but are never stored
      assign w_push_vld[k] = Wt_Valid_i_WB[k] &
                             (Wt_Addr_i_WB[k*ADDR_W +: ADDR_W] != ADDR_W'(ZeroRegAddr));
      assign w_pop[k]      = w_gnt_vld & (w_gnt_idx == RR_W'(k));

      wb_chan_fifo #(
         .DATA_W (DATA_W),
         .ADDR_W (ADDR_W),
         .DEPTH  (FIFO_DEPTH)
      ) u_fifo (
         .i_clk        (clk_i_WB),
         .i_rst_n      (rst_n_i_WB),
         .i_flush      (flush_i_WB),
         .i_push       (w_push_vld[k]),
         .i_push_addr  (Wt_Addr_i_WB[k*ADDR_W +: ADDR_W]),
         .i_push_dat   (Wt_Data_i_WB[k*DATA_W +: DATA_W]),
         .i_pop        (w_pop[k]),
         .o_head_addr  (w_head_addr[k]),
         .o_head_dat   (w_head_dat[k]),
         .o_full       (w_full[k]),
         .o_empty      (w_empty[k]),
         .i_query_addr (Query_Addr_i_WB),
         .o_match      (w_match[k])
      );
   end

   assign Wt_Ready_o_WB = ~w_full;

   // Grant the first non-empty head, scanning from index 0 (fixed) or from the RR pointer;
   // scanning downwards lets the smallest search offset win the last assignment
   always_comb begin
      w_gnt_vld = 1'b0;
      w_gnt_idx = '0;
      for (int off = NUM_CH - 1; off >= 0; off--) begin
         logic [RR_W-1:0] v_idx;
         if (ARB_MODE == ARB_RR) v_idx = RR_W'((int'(r_rr_ptr) + off) % NUM_CH);
         else                    v_idx = RR_W'(off);
         if (!w_empty[v_idx]) begin
            w_gnt_vld = 1'b1;
            w_gnt_idx = v_idx;
         end
      end
   end

   // Round-robin pointer moves past the granted channel; held on idle and on flush
   always_ff @(posedge clk_i_WB or negedge rst_n_i_WB) begin
      if (!rst_n_i_WB) begin
         r_rr_ptr <= '0;
      end else if (!flush_i_WB && w_gnt_vld && (ARB_MODE == ARB_RR)) begin
         r_rr_ptr <= RR_W'(wrap_inc(int'(w_gnt_idx), NUM_CH));
      end
   end

   // Registered regfile write port; data/addr hold when no write is issued
   always_ff @(posedge clk_i_WB or negedge rst_n_i_WB) begin
      if (!rst_n_i_WB) begin
         r_wt_dat  <= DATA_W'(ZeroRegData);
         r_wt_addr <= ADDR_W'(ZeroRegAddr);
         r_wt_en   <= 1'b0;
      end else if (flush_i_WB) begin
         r_wt_en   <= 1'b0;
      end else if (w_gnt_vld) begin
         r_wt_dat  <= w_head_dat[w_gnt_idx];
         r_wt_addr <= w_head_addr[w_gnt_idx];
         r_wt_en   <= 1'b1;
      end else begin
         r_wt_en   <= 1'b0;
      end
   end

   assign Wt_Data_o_WB    = r_wt_dat;
   assign Wt_Addr_o_WB    = r_wt_addr;
   assign Wt_Enable_o_WB  = r_wt_en;
   // A write in the output register is still pending until the regfile takes it
   assign Query_Busy_o_WB = (Query_Addr_i_WB != ADDR_W'(ZeroRegAddr)) &
                            ((|w_match) | (r_wt_en & (r_wt_addr == Query_Addr_i_WB)));
   assign Idle_o_WB       = (&w_empty) & ~r_wt_en;

endmodule

// File: tb/tb_wb_multi_stage.sv
// Bench for wb_multi_stage: fixed-priority and round-robin instances share stimulus.
// Latency: queue-based reference model stepped once per clock edge.
// Backpressure: model accepts only when its own queue has room before the edge.
module tb_wb_multi_stage;

   localparam int NCH   = 2;
   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int DEPTH = 4;
   localparam int EW    = AW + DW;

   logic              clk;
   logic              rst_n;
   logic              flush;
   logic [NCH-1:0]    vld;
   logic [NCH*DW-1:0] dat;
   logic [NCH*AW-1:0] addr;
   logic [AW-1:0]     qaddr;

   logic [NCH-1:0]    rdy    [2];
   logic [DW-1:0]     o_dat  [2];
   logic [AW-1:0]     o_addr [2];
   logic              o_en   [2];
   logic              o_busy [2];
   logic              o_idle [2];

   // Reference model state; index 0 = fixed priority, 1 = round robin
   logic [EW-1:0]     mq [2*NCH][$];
   logic              m_en   [2];
   logic [AW-1:0]     m_addr [2];
   logic [DW-1:0]     m_dat  [2];
   int                m_rr   [2];
   logic [AW-1:0]     out_log [2][$];

   int n_chk;
   int n_bad;
   int x0_seen;

   wb_multi_stage #(.DATA_W(DW), .ADDR_W(AW), .NUM_CH(NCH), .FIFO_DEPTH(DEPTH), .ARB_MODE(0)) u_dut_fix (
      .clk_i_WB(clk), .rst_n_i_WB(rst_n), .flush_i_WB(flush),
      .Wt_Valid_i_WB(vld), .Wt_Ready_o_WB(rdy[0]), .Wt_Data_i_WB(dat), .Wt_Addr_i_WB(addr),
      .Query_Addr_i_WB(qaddr), .Query_Busy_o_WB(o_busy[0]),
      .Wt_Data_o_WB(o_dat[0]), .Wt_Addr_o_WB(o_addr[0]), .Wt_Enable_o_WB(o_en[0]),
      .Idle_o_WB(o_idle[0]));

   wb_multi_stage #(.DATA_W(DW), .ADDR_W(AW), .NUM_CH(NCH), .FIFO_DEPTH(DEPTH), .ARB_MODE(1)) u_dut_rr (
      .clk_i_WB(clk), .rst_n_i_WB(rst_n), .flush_i_WB(flush),
      .Wt_Valid_i_WB(vld), .Wt_Ready_o_WB(rdy[1]), .Wt_Data_i_WB(dat), .Wt_Addr_i_WB(addr),
      .Query_Addr_i_WB(qaddr), .Query_Busy_o_WB(o_busy[1]),
      .Wt_Data_o_WB(o_dat[1]), .Wt_Addr_o_WB(o_addr[1]), .Wt_Enable_o_WB(o_en[1]),
      .Idle_o_WB(o_idle[1]));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2*NCH; i++) mq[i].delete();
      for (int m = 0; m < 2; m++) begin
         m_en[m] = 1'b0; m_addr[m] = '0; m_dat[m] = '0; m_rr[m] = 0;
      end
   endtask

   function automatic logic [NCH-1:0] exp_rdy(input int m);
      logic [NCH-1:0] r;
      for (int c = 0; c < NCH; c++) r[c] = (mq[m*NCH+c].size() < DEPTH);
      return r;
   endfunction

   function automatic logic exp_busy(input int m);
      if (qaddr == '0) return 1'b0;
      if (m_en[m] && m_addr[m] == qaddr) return 1'b1;
      for (int c = 0; c < NCH; c++)
         foreach (mq[m*NCH+c][j])
            if (mq[m*NCH+c][j][EW-1:DW] == qaddr) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic exp_idle(input int m);
      for (int c = 0; c < NCH; c++) if (mq[m*NCH+c].size() != 0) return 1'b0;
      return !m_en[m];
   endfunction

   // One clock edge of the behavioural model
   task automatic model_step(input int m);
      logic [NCH-1:0] r;
      logic [EW-1:0]  e;
      int             g;
      r = exp_rdy(m);
      g = -1;
      for (int off = 0; off < NCH; off++) begin
         int c;
         c = (m == 0) ? off : (m_rr[m] + off) % NCH;
         if (g < 0 && mq[m*NCH+c].size() > 0) g = c;
      end
      if (flush) begin
         for (int c = 0; c < NCH; c++) mq[m*NCH+c].delete();
         m_en[m] = 1'b0;
      end else begin
         if (g >= 0) begin
            e = mq[m*NCH+g].pop_front();
            m_addr[m] = e[EW-1:DW];
            m_dat[m]  = e[DW-1:0];
            m_en[m]   = 1'b1;
            if (m == 1) m_rr[m] = (g + 1) % NCH;
         end else begin
            m_en[m] = 1'b0;
         end
         for (int c = 0; c < NCH; c++)
            if (vld[c] && r[c] && addr[c*AW +: AW] != '0)
               mq[m*NCH+c].push_back({addr[c*AW +: AW], dat[c*DW +: DW]});
      end
   endtask

   task automatic compare_all();
      for (int m = 0; m < 2; m++) begin
         chk($sformatf("rdy%0d", m),  32'(rdy[m]),    32'(exp_rdy(m)));
         chk($sformatf("en%0d", m),   32'(o_en[m]),   32'(m_en[m]));
         chk($sformatf("addr%0d", m), 32'(o_addr[m]), 32'(m_addr[m]));
         chk($sformatf("dat%0d", m),  o_dat[m],       m_dat[m]);
         chk($sformatf("busy%0d", m), 32'(o_busy[m]), 32'(exp_busy(m)));
         chk($sformatf("idle%0d", m), 32'(o_idle[m]), 32'(exp_idle(m)));
         if (o_en[m]) begin
            out_log[m].push_back(o_addr[m]);
            if (o_addr[m] == '0) x0_seen++;
         end
      end
   endtask

   // Compare, take one clock edge, advance the model; returns at posedge+1
   task automatic tick();
      #1;
      compare_all();
      @(posedge clk);
      model_step(0);
      model_step(1);
      #1;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 50 && !(o_idle[0] && o_idle[1]); i++) tick();
      chk("drain_idle", 32'(o_idle[0] & o_idle[1]), 32'd1);
   endtask

   task automatic set_ch(input int c, input logic [AW-1:0] a, input logic [DW-1:0] d);
      addr[c*AW +: AW] = a;
      dat[c*DW +: DW]  = d;
   endtask

   initial begin
      logic [AW-1:0] a0 [$];
      logic [AW-1:0] a1 [$];
      int            cnt;
      n_chk = 0; n_bad = 0; x0_seen = 0;
      rst_n = 1'b0; flush = 1'b0; vld = '0; dat = '0; addr = '0; qaddr = '0;
      model_reset();
      #12 rst_n = 1'b1;
      @(posedge clk); #1;

      // Single write ch0 addr 5: enable pulses once, one cycle after the edge following accept
      vld = 2'b01; set_ch(0, 5'd5, 32'hDEADBEEF);
      tick();
      vld = '0;
      chk("t2_en_accept", 32'(o_en[0]), 32'd0);
      tick();
      chk("t2_en_fix", 32'(o_en[0]), 32'd1);
      chk("t2_en_rr",  32'(o_en[1]), 32'd1);
      chk("t2_addr",   32'(o_addr[0]), 32'd5);
      chk("t2_data",   o_dat[0], 32'hDEADBEEF);
      tick();
      chk("t2_pulse",  32'(o_en[0]), 32'd0);
      wait_idle();

      // Both channels push 3 writes in the same cycles
      out_log[0].delete(); out_log[1].delete();
      for (int i = 0; i < 3; i++) begin
         vld = 2'b11;
         set_ch(0, AW'(1 + i), $urandom);
         set_ch(1, AW'(10 + i), $urandom);
         tick();
      end
      vld = '0;
      wait_idle();
      chk("t3_fix_n", 32'(out_log[0].size()), 32'd6);
      for (int i = 0; i < 6 && i < out_log[0].size(); i++)
         chk("t3_fix_ord", 32'(out_log[0][i]), (i < 3) ? 32'(1 + i) : 32'(7 + i));
      chk("t3_rr_n", 32'(out_log[1].size()), 32'd6);
      for (int i = 1; i < out_log[1].size(); i++)
         chk("t3_rr_alt", 32'(out_log[1][i] >= 10), 32'(out_log[1][i-1] < 10));
      foreach (out_log[1][i])
         if (out_log[1][i] < 10) a0.push_back(out_log[1][i]); else a1.push_back(out_log[1][i]);
      for (int i = 0; i < 3; i++) begin
         chk("t3_rr_ch0", (i < a0.size()) ? 32'(a0[i]) : 32'hFFFF, 32'(1 + i));
         chk("t3_rr_ch1", (i < a1.size()) ? 32'(a1[i]) : 32'hFFFF, 32'(10 + i));
      end

      // ch0 hogs the port in fixed mode; ch1 fills and must hold its 5th write
      out_log[0].delete(); out_log[1].delete();
      for (int i = 0; i < 4; i++) begin
         vld = 2'b11; set_ch(0, AW'(20 + i), $urandom); set_ch(1, AW'(1 + i), $urandom);
         tick();
      end
      chk("t5_full", 32'(rdy[0][1]), 32'd0);
      for (int i = 0; i < 3; i++) begin
         set_ch(0, AW'(24 + i), $urandom); set_ch(1, 5'd5, 32'h5555_0005);
         tick();
         chk("t5_hold", 32'(rdy[0][1]), 32'd0);
      end
      vld = 2'b10;
      cnt = 0;
      while (!rdy[0][1] && cnt < 20) begin tick(); cnt++; end
      chk("t5_freed", 32'(rdy[0][1]), 32'd1);
      tick();
      vld = '0;
      wait_idle();
      a0.delete();
      foreach (out_log[0][i]) if (out_log[0][i] < 20) a0.push_back(out_log[0][i]);
      chk("t5_ch1_n", 32'(a0.size()), 32'd5);
      for (int i = 0; i < 5 && i < a0.size(); i++) chk("t5_ch1_ord", 32'(a0[i]), 32'(1 + i));

      // x0 write dropped, pending addr 7 seen on query, flush clears everything
      vld = 2'b11; set_ch(0, 5'd0, 32'h1234_5678); set_ch(1, 5'd7, 32'h0000_0777);
      tick();
      vld = '0; qaddr = 5'd7; #1;
      chk("t6_busy_fix", 32'(o_busy[0]), 32'd1);
      chk("t6_busy_rr",  32'(o_busy[1]), 32'd1);
      qaddr = 5'd0; #1;
      chk("t6_busy_q0", 32'(o_busy[0]), 32'd0);
      qaddr = 5'd7; flush = 1'b1;
      tick();
      flush = 1'b0; #1;
      chk("t6_flush_busy", 32'(o_busy[0] | o_busy[1]), 32'd0);
      chk("t6_flush_idle", 32'(o_idle[0] & o_idle[1]), 32'd1);
      tick(); tick();

      // Random traffic with a mid-run asynchronous reset
      for (int i = 0; i < 400; i++) begin
         vld   = NCH'($urandom_range(0, 3));
         for (int c = 0; c < NCH; c++) set_ch(c, AW'($urandom_range(0, 7)), $urandom);
         flush = ($urandom_range(0, 31) == 0);
         qaddr = AW'($urandom_range(0, 7));
         if (i == 200) begin
            qaddr = 5'd3;
            #3 rst_n = 1'b0;
            #1;
            for (int m = 0; m < 2; m++) begin
               chk("rst_en",   32'(o_en[m]),   32'd0);
               chk("rst_addr", 32'(o_addr[m]), 32'd0);
               chk("rst_data", o_dat[m],       32'd0);
               chk("rst_rdy",  32'(rdy[m]),    32'd3);
               chk("rst_idle", 32'(o_idle[m]), 32'd1);
               chk("rst_busy", 32'(o_busy[m]), 32'd0);
            end
            model_reset();
            vld = '0; flush = 1'b0;
            #2 rst_n = 1'b1;
         end
         tick();
      end
      vld = '0; flush = 1'b0;
      wait_idle();
      chk("no_x0_write", 32'(x0_seen), 32'd0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
